// File: rtl/piso_serializer_if.sv
// Load-side handshake bundle for the PISO serializer.
// The producer drives din/load_valid; the serializer returns load_ready.
interface piso_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output din,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  din,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with frame strobe and end-of-word pulse.
// One word per WIDTH+1 cycles at best; bits leave straight from the shift reg.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk1,
    input  logic               rst1,
    piso_serializer_if.slave   load,
    output logic               out1,
    output logic               frame,
    output logic               done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic             idle;
    logic             accept;
    logic             last;
    logic             head;

    assign idle   = (state_q == IDLE);
    assign accept = idle && load.load_valid;
    assign last   = (cnt_q == CW'(WIDTH - 1));

    // The bit on the wire is always the leading end of the shift register.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head = shreg_q[WIDTH-1];
        end else begin : g_lsb
            assign head = shreg_q[0];
        end
    endgenerate

    // Outputs are decoded purely from registered state.
    assign load.load_ready = idle;
    assign frame           = (state_q == SHIFT);
    assign out1            = frame && head;
    assign done            = frame && last;

    // Next-state, shift and count logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = load.din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (MSB_FIRST) begin
                        shreg_d = shreg_q << 1;
                    end else begin
                        shreg_d = shreg_q >> 1;
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; synchronous reset aborts any word in flight.
    always_ff @(posedge clk1) begin
        if (rst1) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
